// File: rtl/counter_pkg.sv
// Shared mode constants and bound-check helper for the modulo counter.
package counter_pkg;

  localparam int unsigned MODE_WRAP     = 0;
  localparam int unsigned MODE_SATURATE = 1;
  localparam int unsigned MODE_LEVEL    = 0;
  localparam int unsigned MODE_EDGE     = 1;

  localparam int unsigned MAX_WIDTH = 32;

  // True when a step in the given direction would leave the 0..max_value range.
  function automatic logic at_bound(input logic [MAX_WIDTH-1:0] value,
                                    input logic                 up,
                                    input logic [MAX_WIDTH-1:0] max_value);
    return up ? (value == max_value) : (value == '0);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a level and flags its rising edge; the register clears on reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sig_q <= 1'b0;
    else     r_sig_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with wrap or saturate at 0..MAX_VALUE.
// Define MOD_COUNTER_LOAD_EN to add the load / load_value parallel-load ports.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE  = MODE_WRAP,
  parameter int unsigned     EDGE_MODE = MODE_EDGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
`ifdef MOD_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("mod_counter: WIDTH must be within 1..32");
    end
    if (MAX_VALUE > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("mod_counter: MAX_VALUE exceeds 2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             w_rise;
  logic             w_step;
  logic             w_at_bound;

  edge_detect u_edge_detect (
    .clk    (clk),
    .rst    (reset),
    .i_sig  (enable),
    .o_rise (w_rise)
  );

  assign w_step     = (EDGE_MODE == MODE_EDGE) ? w_rise : enable;
  assign w_at_bound = at_bound(32'(r_count), up, 32'(MAX_VALUE));

`ifdef MOD_COUNTER_LOAD_EN
  logic [WIDTH-1:0] w_load_val;
  assign w_load_val = (64'(load_value) > MAX_VALUE) ? MAX_CNT : load_value;
`endif

  // Next count: clear beats load beats step; only a bound crossing in wrap mode pulses wrap.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
    end
`ifdef MOD_COUNTER_LOAD_EN
    else if (load) begin
      w_count_nxt = w_load_val;
    end
`endif
    else if (w_step) begin
      if (!w_at_bound) begin
        w_count_nxt = up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
      end else if (SATURATE == MODE_WRAP) begin
        w_count_nxt = up ? '0 : MAX_CNT;
        w_wrap_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = w_at_bound;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three configurations share one stimulus stream.
module tb_mod_counter;

  localparam int unsigned W    = 4;
  localparam int          MAXV = 9;
  localparam int          ND   = 3;
  localparam int unsigned SAT_CFG  [ND] = '{0, 1, 0};
  localparam int unsigned EDGE_CFG [ND] = '{1, 1, 0};

  typedef struct packed {
    logic [ND-1:0][W-1:0] cnt;
    logic [ND-1:0]        wr;
    logic                 up;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, up, clr;
`ifdef MOD_COUNTER_LOAD_EN
  logic         ld;
  logic [W-1:0] lv;
`endif
  logic [ND-1:0][W-1:0] cnt;
  logic [ND-1:0]        tcv;
  logic [ND-1:0]        wrv;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt  [ND];
  bit   m_prev [ND];
  exp_t sb_q [$];

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mod_counter #(
      .WIDTH     (W),
      .MAX_VALUE (MAXV),
      .SATURATE  (SAT_CFG[g]),
      .EDGE_MODE (EDGE_CFG[g])
    ) u_dut (
      .clk        (clk),
      .reset      (rst),
      .enable     (en),
      .up         (up),
      .clear      (clr),
`ifdef MOD_COUNTER_LOAD_EN
      .load       (ld),
      .load_value (lv),
`endif
      .count      (cnt[g]),
      .tc         (tcv[g]),
      .wrap       (wrv[g])
    );
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs between edges and push the state expected after the next edge.
  task automatic cyc(input bit e, input bit u, input bit c,
                     input bit r = 1'b0, input bit l = 1'b0, input int lval = 0);
    exp_t x;
    int   t, nc;
    bit   nw, step;
    @(negedge clk);
    #1;
    rst = r; en = e; up = u; clr = c;
`ifdef MOD_COUNTER_LOAD_EN
    ld = l; lv = W'(lval);
`endif
    x = '0;
    x.up = u;
    for (int i = 0; i < ND; i++) begin
      nw = 1'b0;
      if (r) begin
        m_cnt[i]  = 0;
        m_prev[i] = 1'b0;
      end else begin
        step = (EDGE_CFG[i] == 1) ? (e && !m_prev[i]) : e;
        nc   = m_cnt[i];
        if (c) begin
          nc = 0;
        end else if (l) begin
          nc = (lval > MAXV) ? MAXV : lval;
        end else if (step) begin
          t = m_cnt[i] + (u ? 1 : -1);
          if (t >= 0 && t <= MAXV) nc = t;
          else if (SAT_CFG[i] == 0) begin
            nc = (t + MAXV + 1) % (MAXV + 1);
            nw = 1'b1;
          end
        end
        m_cnt[i]  = nc;
        m_prev[i] = e;
      end
      x.cnt[i] = W'(m_cnt[i]);
      x.wr[i]  = nw;
    end
    sb_q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle with an outstanding expectation, compare all three DUTs.
  initial begin
    exp_t x;
    int   etc;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        for (int i = 0; i < ND; i++) begin
          etc = x.up ? int'(x.cnt[i] == W'(MAXV)) : int'(x.cnt[i] == '0);
          chk($sformatf("count[%0d]", i), int'(cnt[i]), int'(x.cnt[i]));
          chk($sformatf("wrap[%0d]", i),  int'(wrv[i]), int'(x.wr[i]));
          chk($sformatf("tc[%0d]", i),    int'(tcv[i]), etc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;
`ifdef MOD_COUNTER_LOAD_EN
    ld = 1'b0; lv = '0;
`endif
    for (int i = 0; i < ND; i++) begin
      m_cnt[i]  = 0;
      m_prev[i] = 1'b0;
    end

    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < ND; i++) chk($sformatf("reset_count[%0d]", i), int'(cnt[i]), 0);
    cyc(0, 1, 0);

    // 11 up pulses: edge/wrap counter ends at 1, saturating one pins at 9
    for (int k = 0; k < 11; k++) begin
      cyc(1, 1, 0);
      cyc(0, 1, 0);
    end
    settle();
    chk("pulses_wrap_count", int'(cnt[0]), 1);
    chk("pulses_sat_count",  int'(cnt[1]), 9);
    chk("pulses_sat_tc",     int'(tcv[1]), 1);

    // enable held high for 10 cycles
    cyc(0, 1, 1);
    for (int k = 0; k < 10; k++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    settle();
    chk("held_edge_count",  int'(cnt[0]), 1);
    chk("held_level_count", int'(cnt[2]), 0);

    // saturating down from 0
    cyc(0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    settle();
    chk("sat_down_count", int'(cnt[1]), 0);
    chk("sat_down_wrap",  int'(wrv[1]), 0);
    chk("sat_down_tc",    int'(tcv[1]), 1);
    chk("wrap_down_count", int'(cnt[0]), 7);

    // direction change while enable is held
    cyc(0, 1, 1);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);

    for (int k = 0; k < 400; k++) begin
`ifdef MOD_COUNTER_LOAD_EN
      cyc(1'($urandom % 2), 1'($urandom % 2), ($urandom % 16) == 0, 1'b0,
          ($urandom % 12) == 0, int'($urandom % 16));
`else
      cyc(1'($urandom % 2), 1'($urandom % 2), ($urandom % 16) == 0);
`endif
    end

`ifdef MOD_COUNTER_LOAD_EN
    cyc(0, 1, 0);
    cyc(1, 1, 1, 0, 1, 5);
    settle();
    chk("clear_load_step", int'(cnt[0]), 0);
    cyc(0, 1, 0, 0, 1, 12);
    settle();
    for (int i = 0; i < ND; i++) chk($sformatf("load_clamp[%0d]", i), int'(cnt[i]), 9);
`endif

    // asynchronous reset at count 5, enable held through release
    cyc(0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0);
      cyc(0, 1, 0);
    end
    settle();
    chk("pre_reset_count", int'(cnt[0]), 5);
    cyc(1, 1, 0, 1);
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("async_reset_count[%0d]", i), int'(cnt[i]), 0);
      chk($sformatf("async_reset_wrap[%0d]", i),  int'(wrv[i]), 0);
    end
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    settle();
    for (int i = 0; i < ND; i++) chk($sformatf("release_step[%0d]", i), int'(cnt[i]), 1);

    cyc(0, 1, 0);
    @(posedge clk);
    #3;
    chk("scoreboard_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
